toggle_bank: RTL and testbench

TOGGLE_BANK -- requirements
Module: toggle_bank

---
 rtl/toggle_bank.sv | 171 +++++++++++++++++
 tb/tb_toggle_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_bank.sv
// toggle_bank: N independent debounced push-to-toggle channels with a
// global force-off / force-on / freeze mode.
// Optional feature macro: TOGGLE_BANK_COUNT_EN adds the saturating
// toggle event counter and its tog_cnt output port.

// Per-channel press detector: IDLE -> DEB (counting) -> LATCHED.
// A press flips the output once HOLD consecutive high edges are seen;
// it must be released before another press can register.
module toggle_bank_ch #(
  parameter int HOLD = 3,
  parameter int CW   = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       i_togen,
  input  logic [1:0] i_mode,
  output logic       o_z
`ifdef TOGGLE_BANK_COUNT_EN
  ,
  output logic       o_flip
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_DEB, S_LATCHED} state_t;

  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_z, w_z_nxt, w_flip;

  assign w_cnt_inc = r_cnt + 1'b1;

  // State, debounce count and output bit registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_z     <= w_z_nxt;
    end
  end

  // Next-state: force/freeze modes park the FSM so a held press never
  // toggles once normal mode resumes; normal mode runs the debounce.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_z_nxt     = r_z;
    w_flip      = 1'b0;
    if (i_mode != 2'b00) begin
      w_state_nxt = i_togen ? S_LATCHED : S_IDLE;
      w_cnt_nxt   = '0;
      case (i_mode)
        2'b01:   w_z_nxt = 1'b0;
        2'b10:   w_z_nxt = 1'b1;
        default: w_z_nxt = r_z;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_togen) begin
            if (HOLD == 1) begin
              w_flip      = 1'b1;
              w_state_nxt = S_LATCHED;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = S_DEB;
              w_cnt_nxt   = CW'(1);
            end
          end
        end
        S_DEB: begin
          if (!i_togen) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == HOLD_C) begin
            w_flip      = 1'b1;
            w_state_nxt = S_LATCHED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        S_LATCHED: begin
          if (!i_togen) w_state_nxt = S_IDLE;
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
      if (w_flip) w_z_nxt = ~r_z;
    end
  end

  assign o_z = r_z;
`ifdef TOGGLE_BANK_COUNT_EN
  assign o_flip = w_flip;
`endif
endmodule

module toggle_bank #(
  parameter int N    = 4,
  parameter int HOLD = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N-1:0]    togen,
  input  logic [1:0]      mode,
  output logic [N-1:0]    z1,
  output logic            any_on
`ifdef TOGGLE_BANK_COUNT_EN
  ,
  output logic [CNTW-1:0] tog_cnt
`endif
);
  localparam int CW = (HOLD < 2) ? 1 : $clog2(HOLD + 1);

  logic [N-1:0] w_z;
`ifdef TOGGLE_BANK_COUNT_EN
  logic [N-1:0] w_flip;
`endif

  for (genvar g = 0; g < N; g++) begin : g_ch
    toggle_bank_ch #(.HOLD(HOLD), .CW(CW)) u_ch (
      .clk     (clk),
      .clr     (clr),
      .i_togen (togen[g]),
      .i_mode  (mode),
      .o_z     (w_z[g])
`ifdef TOGGLE_BANK_COUNT_EN
      ,
      .o_flip  (w_flip[g])
`endif
    );
  end

  assign z1     = w_z;
  assign any_on = |w_z;

`ifdef TOGGLE_BANK_COUNT_EN
  // Sum is wide enough for a full counter plus up to 32 flips per edge.
  localparam logic [CNTW+5:0] CNT_MAX = {6'b0, {CNTW{1'b1}}};

  logic [5:0]      w_nflip;
  logic [CNTW+5:0] w_sum;
  logic [CNTW-1:0] r_tog_cnt;

  // Count channels flipping at this edge.
  always_comb begin
    w_nflip = '0;
    for (int i = 0; i < N; i++) w_nflip = w_nflip + 6'(w_flip[i]);
  end

  assign w_sum = {6'b0, r_tog_cnt} + {{CNTW{1'b0}}, w_nflip};

  // Saturating accumulate; only reset clears it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                  r_tog_cnt <= '0;
    else if (w_sum > CNT_MAX) r_tog_cnt <= {CNTW{1'b1}};
    else                      r_tog_cnt <= w_sum[CNTW-1:0];
  end

  assign tog_cnt = r_tog_cnt;
`endif
endmodule

// File: tb/tb_toggle_bank.sv
// Randomized + directed bench for toggle_bank against a press-counting
// reference model (N=4, HOLD=3, CNTW=8). Define TOGGLE_BANK_COUNT_EN to
// also check tog_cnt.
module tb_toggle_bank;
  localparam int N    = 4;
  localparam int HOLD = 3;
  localparam int CNTW = 8;
  localparam int CMAX = (1 << CNTW) - 1;

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] togen;
  logic [1:0]   mode;
  logic [N-1:0] z1;
  logic         any_on;
`ifdef TOGGLE_BANK_COUNT_EN
  logic [CNTW-1:0] tog_cnt;
`endif

  toggle_bank #(.N(N), .HOLD(HOLD), .CNTW(CNTW)) dut (
    .clk    (clk),
    .clr    (clr),
    .togen  (togen),
    .mode   (mode),
    .z1     (z1),
    .any_on (any_on)
`ifdef TOGGLE_BANK_COUNT_EN
    ,
    .tog_cnt(tog_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: run length of the current unconsumed press per channel.
  int           m_run [N];
  bit           m_used[N];
  logic [N-1:0] m_z;
  int           m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin m_run[i] = 0; m_used[i] = 0; end
    m_z = '0;
    m_cnt = 0;
  endtask

  // A press is a run of high edges in normal mode; the HOLD-th one flips.
  // Any high edge outside normal mode consumes the press without flipping.
  task automatic m_edge();
    int flips;
    flips = 0;
    if (clr) begin m_reset(); return; end
    for (int i = 0; i < N; i++) begin
      if (!togen[i]) begin
        m_run[i] = 0; m_used[i] = 0;
      end else if (mode != 2'b00) begin
        m_run[i] = 0; m_used[i] = 1;
      end else if (!m_used[i]) begin
        m_run[i]++;
        if (m_run[i] == HOLD) begin
          m_z[i] = ~m_z[i]; m_used[i] = 1; m_run[i] = 0; flips++;
        end
      end
    end
    if (mode == 2'b01) m_z = '0;
    if (mode == 2'b10) m_z = '1;
    m_cnt = (m_cnt + flips > CMAX) ? CMAX : m_cnt + flips;
  endtask

  task automatic compare(input string tag);
    chk({tag, ".z1"}, 32'(z1), 32'(m_z));
    chk({tag, ".any_on"}, 32'(any_on), 32'(|m_z));
`ifdef TOGGLE_BANK_COUNT_EN
    chk({tag, ".cnt"}, 32'(tog_cnt), 32'(m_cnt));
`endif
  endtask

  // Apply inputs, take one edge, check just after it.
  task automatic step(input logic [N-1:0] t, input logic [1:0] m, input string tag);
    togen = t; mode = m;
    @(posedge clk);
    m_edge();
    #1 compare(tag);
  endtask

  task automatic press(input logic [N-1:0] t, input int n, input string tag);
    for (int k = 0; k < n; k++) step(t, 2'b00, tag);
  endtask

  initial begin
    logic [N-1:0] rt;
    logic [1:0]   rm;
    clr = 1'b1; togen = '0; mode = 2'b00;
    m_reset();
    #2 compare("reset");
    chk("reset.z1_const", 32'(z1), 32'h0);
    @(negedge clk); clr = 1'b0;

    // Single press, then long hold without repeat.
    press(4'b0001, 2, "p1");
    chk("p1.not_yet", 32'(z1), 32'h0);
    press(4'b0001, 1, "p1");
    chk("p1.flip", 32'(z1), 32'h1);
    press(4'b0001, 10, "p1.hold");
    chk("p1.no_repeat", 32'(z1), 32'h1);
    press(4'b0000, 1, "p1.rel");

    // Glitch in the middle of debounce is ignored.
    press(4'b0001, 2, "gl");
    press(4'b0000, 1, "gl");
    press(4'b0001, 2, "gl");
    chk("gl.not_yet", 32'(z1), 32'h1);
    press(4'b0001, 1, "gl");
    chk("gl.flip", 32'(z1), 32'h0);
    press(4'b0000, 1, "gl.rel");

    // All channels together.
    press(4'b1111, 3, "all");
    chk("all.z1", 32'(z1), 32'hF);
    chk("all.any_on", 32'(any_on), 32'h1);
    press(4'b0000, 1, "all.rel");
    press(4'b1010, 3, "mk0101");
    press(4'b0000, 1, "mk0101");
    chk("mk0101", 32'(z1), 32'h5);

    // Force on, force off, freeze with a held press, back to normal.
    step(4'b0000, 2'b10, "fon");
    chk("fon.z1", 32'(z1), 32'hF);
    step(4'b0000, 2'b01, "foff");
    chk("foff.any_on", 32'(any_on), 32'h0);
    for (int k = 0; k < 5; k++) step(4'b0010, 2'b11, "frz");
    for (int k = 0; k < 4; k++) step(4'b0010, 2'b00, "frz.ret");
    chk("frz.no_flip", 32'(z1), 32'h0);
    step(4'b0000, 2'b00, "frz.rel");

    // Asynchronous reset mid-debounce.
    press(4'b0100, 2, "arst");
    #2 clr = 1'b1;
    #1 m_reset();
    compare("arst.now");
    chk("arst.z1_now", 32'(z1), 32'h0);
    step(4'b0100, 2'b00, "arst.held");
    @(negedge clk); clr = 1'b0;
    press(4'b0100, 2, "arst.post");
    chk("arst.not_yet", 32'(z1), 32'h0);
    press(4'b0100, 1, "arst.post");
    chk("arst.flip", 32'(z1), 32'h4);
    press(4'b0000, 1, "arst.rel");

    // Drive the counter toward and past saturation.
    for (int p = 0; p < 66; p++) begin
      press(4'b1111, 3, "sat");
      press(4'b0000, 1, "sat");
    end
`ifdef TOGGLE_BANK_COUNT_EN
    chk("sat.cnt", 32'(tog_cnt), 32'(CMAX));
`endif

    // Randomized phase with occasional asynchronous reset.
    rt = '0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) rt = N'($urandom);
      rm = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 clr = 1'b1;
        #1 m_reset();
        compare("rnd.rst");
        @(negedge clk); clr = 1'b0;
      end
      step(rt, rm, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
